ps2_player_ctrl: RTL
====================

// Module: ps2_player_ctrl
// PURPOSE
//  PS/2 keyboard front end that turns raw ps2_clk/ps2_data into the per-player
//  move/bubble controls consumed by calc: player*_moveen, player*_move[1:0],
//  player*_bubble. Sits directly upstream of calc, same clock domain.
//  Player 1 keys: W/S/A/D plus Space. Player 2 keys: arrow keys plus Enter.
//  All codes are scan code set 2.
// PARAMETERS
//  FILTER_LEN   8      cycles ps2_clk must be stable before a level change is accepted
//  TIMEOUT_CYC  20000  idle cycles mid-frame before a partial frame is dropped
// PORTS
//  clk             in   1  system clock, only clock
//  rst             in   1  asynchronous, active-low reset
//  ps2_clk         in   1  raw PS/2 clock (async)
//  ps2_data        in   1  raw PS/2 data (async)
//  player1_moveen  out  1  P1 direction key held
//  player1_move    out  2  P1 direction: 0=up 1=down 2=left 3=right
//  player1_bubble  out  1  one-cycle pulse on P1 bubble press
//  player2_moveen  out  1  P2 direction key held
//  player2_move    out  2  P2 direction (same encoding)
//  player2_bubble  out  1  one-cycle pulse on P2 bubble press
//  frame_err       out  1  one-cycle pulse on bad start/parity/stop or timeout
// BEHAVIOUR
//  Reset: rst=0 asynchronously clears all state. Every output is 0 and all
//   held flags are 0. The receiver returns to bit 0 and the decoder to IDLE.
//   Reset mid-frame drops the partial byte with no pulse.
//  Sync: 2-FF synchronisers on ps2_clk and ps2_data, then a FILTER_LEN glitch
//   filter on clk. ps2_data is sampled on the filtered ps2_clk falling edge.
//  Frame: 11 bits = start(0), 8 data bits LSB first, odd parity, stop(1).
//   - Good frame: byte_valid for 1 cycle.
//   - Bad start/parity/stop: frame_err pulse, byte discarded.
//   - No falling edge for TIMEOUT_CYC cycles while bit count is nonzero:
//     counter cleared, frame_err pulse.
//  Decoder FSM:
//   - IDLE: E0 -> EXT; F0 -> BRK; other byte -> make(code,ext=0).
//   - EXT: F0 -> EXT_BRK; other byte -> make(code,ext=1), then IDLE.
//   - BRK: byte -> break(code,ext=0), then IDLE.
//   - EXT_BRK: byte -> break(code,ext=1), then IDLE.
//   - E0 or F0 arriving in BRK or EXT_BRK is taken as the code, then IDLE.
//  Key map:
//   - P1: 1D up, 1B down, 1C left, 23 right, 29 bubble. Plain codes only.
//   - P2: E0 75 up, E0 72 down, E0 6B left, E0 74 right, 5A bubble.
//     E0 5A (keypad Enter) is ignored.
//   - Unmapped codes are ignored.
//  Held flags: make sets, break clears, per key.
//  Direction select, per player:
//   - A make of a direction key not already held makes that key the current
//     direction. Typematic repeat of a held key changes nothing.
//   - Releasing the current direction while others are held falls back by
//     fixed priority up > down > left > right.
//   - moveen = OR of that player's 4 direction held flags.
//   - move keeps its last value when moveen=0.
//  Bubble: pulse only on make when the key is not already held, so typematic
//   repeats give no pulse. A new press requires a break first.
//  Latency: outputs are registered and update 1 clk after byte_valid of the
//   final code byte.
//  Two players never share a key, so their outputs are fully independent.
// STRUCTURE
//  Shared package/header holds:
//   - scan-code constants: KEY_W..KEY_ENTER, PS2_EXT=8'hE0, PS2_BRK=8'hF0
//   - direction encodings DIR_UP..DIR_RIGHT, which calc also uses
//   - decoder state encodings
//  Sub-module ps2_rx: sync + filter + 11-bit frame shifter + parity/timeout.
//   Outputs byte[7:0], byte_valid, frame_err.
//  Top level: decoder FSM, held flags, direction select.
// TESTING
//  1 rst=0 for 3 cycles mid-frame, then release -> all outputs 0, next good
//    frame 1D decodes normally.
//  2 Frame 1D -> player1_moveen=1, move=0, 1 clk after byte_valid;
//    frames F0 1D -> moveen=0, move stays 0.
//  3 P1: 1D, then 23, then F0 23 -> move 0, then 3, then back to 0, moveen
//    stays 1; then F0 1D -> moveen=0.
//  4 E0 6B -> player2_move=2, moveen=1; 5A, 5A, F0 5A, 5A -> exactly 2
//    player2_bubble pulses; E0 5A -> no pulse.
//  5 Frame 29 sent with bad parity -> frame_err pulse, no player1_bubble;
//    a 4-bit partial frame plus TIMEOUT_CYC idle -> frame_err, then 29 ->
//    one player1_bubble pulse.
//  6 Glitch on ps2_clk shorter than FILTER_LEN cycles during a frame ->
//    byte still received correctly.

Source files
------------

// File: rtl/ps2_player_ctrl_pkg.sv
// Shared constants for the PS/2 player front end: scan codes (set 2),
// direction encodings shared with calc, decoder states and key lookup.
package ps2_player_ctrl_pkg;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  typedef struct packed {
    logic       hit;
    logic       player;  // 0 = player 1, 1 = player 2
    logic       bubble;
    logic [1:0] dir;
  } key_t;

  function automatic key_t key_lookup(input logic [7:0] code, input logic ext);
    key_t k;
    k = '0;
    if (!ext) begin
      case (code)
        KEY_W:     begin k.hit = 1'b1; k.dir = DIR_UP;    end
        KEY_S:     begin k.hit = 1'b1; k.dir = DIR_DOWN;  end
        KEY_A:     begin k.hit = 1'b1; k.dir = DIR_LEFT;  end
        KEY_D:     begin k.hit = 1'b1; k.dir = DIR_RIGHT; end
        KEY_SPACE: begin k.hit = 1'b1; k.bubble = 1'b1;   end
        KEY_ENTER: begin k.hit = 1'b1; k.bubble = 1'b1; k.player = 1'b1; end
        default:   k = '0;
      endcase
    end else begin
      case (code)
        KEY_UP:    begin k.hit = 1'b1; k.player = 1'b1; k.dir = DIR_UP;    end
        KEY_DOWN:  begin k.hit = 1'b1; k.player = 1'b1; k.dir = DIR_DOWN;  end
        KEY_LEFT:  begin k.hit = 1'b1; k.player = 1'b1; k.dir = DIR_LEFT;  end
        KEY_RIGHT: begin k.hit = 1'b1; k.player = 1'b1; k.dir = DIR_RIGHT; end
        default:   k = '0;
      endcase
    end
    return k;
  endfunction

  // Fallback when the current direction is released: up > down > left > right.
  function automatic logic [1:0] dir_prio(input logic [3:0] held);
    if (held[DIR_UP])        return DIR_UP;
    else if (held[DIR_DOWN]) return DIR_DOWN;
    else if (held[DIR_LEFT]) return DIR_LEFT;
    else                     return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: input synchronisers, glitch filter on ps2_clk, 11-bit frame
// shifter with start/parity/stop checking and a mid-frame idle timeout.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          fall;
  logic [10:0]   frame;

  assign frame = {data_sync_q[1], shift_q};

  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = FILT_LOAD;
    fall       = 1'b0;
    // A new level is accepted only after FILTER_LEN consecutive differing samples.
    if (clk_sync_q[1] != clk_filt_q) begin
      if (filt_cnt_q == '0) begin
        clk_filt_d = clk_sync_q[1];
        fall       = clk_filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = TMO_LOAD;
    if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!frame[0] && frame[10] && (^frame[9:1])) begin
          byte_d  = frame[8:1];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {data_sync_q[1], shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == '0) begin
        bit_cnt_d = 4'd0;
        err_d     = 1'b1;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= FILT_LOAD;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      tmo_q       <= TMO_LOAD;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign rx_byte    = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_player_ctrl.sv
// PS/2 keyboard to per-player move/bubble controls: make/break decoder,
// per-key held flags and direction selection with priority fallback.
//  state      | meaning
//  ST_IDLE    | waiting for a code, prefix or break byte
//  ST_EXT     | E0 seen, next byte is an extended make (or F0)
//  ST_BRK     | F0 seen, next byte is a plain break
//  ST_EXT_BRK | E0 F0 seen, next byte is an extended break
module ps2_player_ctrl
  import ps2_player_ctrl_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       player1_moveen,
  output logic [1:0] player1_move,
  output logic       player1_bubble,
  output logic       player2_moveen,
  output logic [1:0] player2_move,
  output logic       player2_bubble,
  output logic       frame_err
);

  logic [7:0]      rx_byte;
  logic            byte_valid;

  logic [1:0]      state_q, state_d;
  logic [1:0][3:0] held_q, held_d;
  logic [1:0][1:0] cur_q, cur_d;
  logic [1:0]      bub_held_q, bub_held_d;
  logic [1:0]      bub_pulse_q, bub_pulse_d;
  logic [1:0]      moveen_q, moveen_d;
  logic            ev_valid, ev_make, ev_ext;
  key_t            key;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_comb begin
    state_d  = state_q;
    ev_valid = 1'b0;
    ev_make  = 1'b0;
    ev_ext   = 1'b0;
    if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == PS2_EXT)      state_d = ST_EXT;
          else if (rx_byte == PS2_BRK) state_d = ST_BRK;
          else begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_byte == PS2_BRK) state_d = ST_EXT_BRK;
          else begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
            ev_ext   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          ev_valid = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          ev_valid = 1'b1;
          ev_ext   = 1'b1;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  assign key = key_lookup(rx_byte, ev_ext);

  always_comb begin
    held_d      = held_q;
    cur_d       = cur_q;
    bub_held_d  = bub_held_q;
    bub_pulse_d = '0;
    if (ev_valid && key.hit) begin
      if (key.bubble) begin
        if (ev_make) begin
          bub_pulse_d[key.player] = ~bub_held_q[key.player];
          bub_held_d[key.player]  = 1'b1;
        end else begin
          bub_held_d[key.player] = 1'b0;
        end
      end else if (ev_make) begin
        // Typematic repeat of an already-held key must not steal the direction.
        if (!held_q[key.player][key.dir]) cur_d[key.player] = key.dir;
        held_d[key.player][key.dir] = 1'b1;
      end else begin
        held_d[key.player][key.dir] = 1'b0;
        if ((cur_q[key.player] == key.dir) && (held_d[key.player] != 4'd0))
          cur_d[key.player] = dir_prio(held_d[key.player]);
      end
    end
    moveen_d[0] = |held_d[0];
    moveen_d[1] = |held_d[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      held_q      <= '0;
      cur_q       <= '0;
      bub_held_q  <= '0;
      bub_pulse_q <= '0;
      moveen_q    <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      cur_q       <= cur_d;
      bub_held_q  <= bub_held_d;
      bub_pulse_q <= bub_pulse_d;
      moveen_q    <= moveen_d;
    end
  end

  assign player1_moveen = moveen_q[0];
  assign player1_move   = cur_q[0];
  assign player1_bubble = bub_pulse_q[0];
  assign player2_moveen = moveen_q[1];
  assign player2_move   = cur_q[1];
  assign player2_bubble = bub_pulse_q[1];

endmodule
